pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register for the D/X, X/M and M/W boundaries.
- Replaces per-signal dff/Register banks with one block carrying a control bundle, a data bundle and a register-tag bundle.
- Adds a valid/ready handshake, a one-entry skid buffer so a stall never drops a beat, and a synchronous flush that inserts a bubble.
- Sits between two pipeline stages; upstream is hazard/decode logic, downstream is the next stage's datapath.

Parameters:
CTRL_W, 11, width of control bundle (ALUsrc..LoadPartial); bit 0 defined as RegWrite-class write-enable
DATA_W, 96, width of data bundle (six 16-bit fields: instruction, a, b, imm, oldPC, newPC)
TAG_W, 12, width of register-tag bundle (reg_dest, Source1, Source2, 4 bits each)
SKID_EN, 1, 1 = two-entry (main + skid), 0 = single-entry with combinational ready

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
in_ctrl  input  CTRL_W  control bundle in
in_data  input  DATA_W  data bundle in
in_tag  input  TAG_W  register tags in
out_valid  output  1  main entry holds a beat
out_ready  input  1  downstream consumes this cycle
out_ctrl  output  CTRL_W  control bundle out, forced 0 when out_valid=0
out_data  output  DATA_W  data bundle out, unmasked
out_tag  output  TAG_W  tags out, unmasked
occupancy  output  2  entries held (0..2)

Behaviour:
- Reset (rst=0, asynchronous): all storage cleared to 0; out_valid=0; occupancy=0; out_ctrl/out_data/out_tag=0; in_ready=1 as soon as reset deasserts.
- Transfer rules: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when the block is empty.
- States (SKID_EN=1):
  - EMPTY: accept -> ONE, main loaded.
  - ONE:
    - accept & pop -> ONE, main reloaded.
    - accept & !pop -> FULL, skid loaded.
    - !accept & pop -> EMPTY.
  - FULL: pop -> ONE, skid moves to main; no accept is possible because in_ready=0.
- in_ready (SKID_EN=1) = (state != FULL). It is registered and has no combinational path from out_ready.
- SKID_EN=0: single entry only.
  - in_ready = !out_valid | out_ready (combinational).
  - No FULL state; occupancy never exceeds 1.
- Ordering: strictly FIFO; the skid entry is never bypassed.
- Flush:
  - Takes priority over accept and pop in the same cycle.
  - Next state is EMPTY and out_valid=0.
  - The beat offered on in_* during the flush cycle is dropped; upstream treats it as squashed.
  - Data and tag storage is retained, not cleared; only valid bits clear.
- Bubble masking: out_ctrl = main_ctrl & {CTRL_W{out_valid}}, so an invalid stage never asserts write, memory or halt controls downstream.
- occupancy = number of held entries: EMPTY=0, ONE=1, FULL=2.
- Reset mid-transfer: all held beats are lost with no partial update; the block re-enters EMPTY.
- Stability: while out_valid=1 & out_ready=0, out_* is held stable. An assertion checks this.

Decomposition:
- Package pipe_stage_pkg holds:
  - typedef enum {EMPTY, ONE, FULL} for the state;
  - localparam bit indices for control fields (CTRL_REGWRITE=0, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_HALT, ...);
  - field-offset localparams for the 16-bit data slices and 4-bit tag slices.
- Sub-module stage_entry: one enable-loaded register of width CTRL_W+DATA_W+TAG_W with async active-low clear. Instantiated as main and skid; skid is generated only when SKID_EN=1.

Test Plan:
1. Reset then single beat: in_valid=1, in_ctrl=11'h401, in_data[15:0]=16'hA5A5, out_ready=1.
   -> Next cycle out_valid=1, out_ctrl=11'h401, out_data[15:0]=16'hA5A5; occupancy returns to 0 after the pop.
2. Stall fill: out_ready=0; send beats 16'h0001, 16'h0002, 16'h0003 back-to-back.
   -> Beats 1 and 2 accepted, in_ready=0 after beat 2, occupancy=2, beat 3 held upstream.
   -> Release out_ready: outputs 1, 2, 3 in order, none lost.
3. Flush while FULL with in_valid=1, in_data[15:0]=16'h00FF.
   -> Next cycle out_valid=0, out_ctrl=0, occupancy=0; 16'h00FF never appears at the output.
4. Streaming: in_valid=1 and out_ready=1 held for 8 cycles with incrementing data 0..7.
   -> One beat per cycle, out_data tracks input by 1 cycle, occupancy stays 1.
5. Async reset pulse mid-stall at FULL (rst low for half a cycle).
   -> out_valid=0 and occupancy=0 immediately, without waiting for a clock edge; after release in_ready=1.
6. SKID_EN=0 build, out_ready=0 with a beat held.
   -> in_ready=0; raising out_ready in the same cycle as in_valid=1 gives accept and pop together, and the new beat appears next cycle.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// Shared types and field layout for the pipeline-stage register.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Control bundle bit positions; bit 0 is the register-file write enable
    localparam int unsigned CTRL_REGWRITE    = 0;
    localparam int unsigned CTRL_MEMREAD     = 1;
    localparam int unsigned CTRL_MEMWRITE    = 2;
    localparam int unsigned CTRL_HALT        = 3;
    localparam int unsigned CTRL_ALUSRC      = 4;
    localparam int unsigned CTRL_ALUOP0      = 5;
    localparam int unsigned CTRL_ALUOP1      = 6;
    localparam int unsigned CTRL_MEMTOREG    = 7;
    localparam int unsigned CTRL_BRANCH      = 8;
    localparam int unsigned CTRL_JUMP        = 9;
    localparam int unsigned CTRL_LOADPARTIAL = 10;

    // Data bundle: six 16-bit fields
    localparam int unsigned DATA_FIELD_W    = 16;
    localparam int unsigned DATA_INSTR_LSB  = 0;
    localparam int unsigned DATA_A_LSB      = 16;
    localparam int unsigned DATA_B_LSB      = 32;
    localparam int unsigned DATA_IMM_LSB    = 48;
    localparam int unsigned DATA_OLDPC_LSB  = 64;
    localparam int unsigned DATA_NEWPC_LSB  = 80;

    // Tag bundle: three 4-bit register specifiers
    localparam int unsigned TAG_FIELD_W     = 4;
    localparam int unsigned TAG_DEST_LSB    = 0;
    localparam int unsigned TAG_SRC1_LSB    = 4;
    localparam int unsigned TAG_SRC2_LSB    = 8;

    function automatic logic [1:0] state_occupancy(input stage_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/stage_entry.sv
// One enable-loaded storage entry (ctrl+data+tag) with async active-low clear.
module stage_entry #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional one-entry skid
// buffer and synchronous flush that leaves a bubble.
module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int unsigned CTRL_W  = 11,
    parameter int unsigned DATA_W  = 96,
    parameter int unsigned TAG_W   = 12,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy
);

    localparam int unsigned ENTRY_W = CTRL_W + DATA_W + TAG_W;

    stage_state_e        state_q, state_d;
    logic                accept, pop;
    logic                main_load, skid_load, main_from_skid;
    logic                hold_q;
    logic [ENTRY_W-1:0]  in_bus, main_d, main_q, skid_q;

    assign in_bus    = {in_ctrl, in_data, in_tag};
    assign out_valid = (state_q != EMPTY);
    // With the skid entry, ready depends only on state; without it, ready must look at out_ready
    assign in_ready  = SKID_EN ? (state_q != FULL) : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign main_d    = main_from_skid ? skid_q : in_bus;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    // Next state and entry load enables; flush wins over accept and pop
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept && SKID_EN) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    stage_entry #(.W(ENTRY_W)) u_main (
        .clk   (clk),
        .rst_n (rst),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            stage_entry #(.W(ENTRY_W)) u_skid (
                .clk   (clk),
                .rst_n (rst),
                .load  (skid_load),
                .d     (in_bus),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    // Bubble masking keeps write/memory/halt controls quiet when no beat is held
    assign out_ctrl  = main_q[ENTRY_W-1 -: CTRL_W] & {CTRL_W{out_valid}};
    assign out_data  = main_q[TAG_W +: DATA_W];
    assign out_tag   = main_q[TAG_W-1:0];
    assign occupancy = state_occupancy(state_q);

    // Marks a cycle whose outputs must be repeated unchanged on the next edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= 1'b0;
        else      hold_q <= out_valid && !out_ready && !flush;
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
        hold_q |-> (out_valid && $stable(out_ctrl) && $stable(out_data) && $stable(out_tag)));

    a_bubble_no_write: assert property (@(posedge clk) disable iff (!rst)
        !out_valid |-> !out_ctrl[CTRL_REGWRITE]);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: skid build plus a single-entry build.
module tb_pipe_stage_skid;

    localparam int unsigned CW = 11;
    localparam int unsigned DW = 96;
    localparam int unsigned TW = 12;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [TW-1:0] in_tag, out_tag;
    logic [1:0]    occupancy;

    logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
    logic [DW-1:0] s0_in_data, s0_out_data;
    logic [TW-1:0] s0_in_tag, s0_out_tag;
    logic [1:0]    s0_occupancy;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    beat_t exp0_q[$];
    beat_t mon_e, mon0_e;
    beat_t ba, bb;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_tag(out_tag),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .in_ctrl(s0_in_ctrl), .in_data(s0_in_data), .in_tag(s0_in_tag),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .out_ctrl(s0_out_ctrl), .out_data(s0_out_data), .out_tag(s0_out_tag),
        .occupancy(s0_occupancy)
    );

    function automatic beat_t mk(input logic [CW-1:0] c, input logic [15:0] v);
        beat_t b;
        b.c = c;
        b.d = {v + 16'h5000, v + 16'h4000, v ^ 16'h00F0, ~v, v + 16'h1000, v};
        b.t = v[11:0] ^ 12'h5A3;
        return b;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t b);
        in_valid = 1'b1;
        in_ctrl  = b.c;
        in_data  = b.d;
        in_tag   = b.t;
    endtask

    task automatic drive0(input beat_t b);
        s0_in_valid = 1'b1;
        s0_in_ctrl  = b.c;
        s0_in_data  = b.d;
        s0_in_tag   = b.t;
    endtask

    // Monitors: every presented-and-consumed beat must match the queue head
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL skid_unexpected actual=%0h expected=none", {out_ctrl, out_data, out_tag});
            end else begin
                mon_e = exp_q.pop_front();
                chk("skid_out", 128'({out_ctrl, out_data, out_tag}), 128'(mon_e));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && s0_out_valid && s0_out_ready) begin
            if (exp0_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL single_unexpected actual=%0h expected=none", {s0_out_ctrl, s0_out_data, s0_out_tag});
            end else begin
                mon0_e = exp0_q.pop_front();
                chk("single_out", 128'({s0_out_ctrl, s0_out_data, s0_out_tag}), 128'(mon0_e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0; in_tag = '0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
        s0_in_ctrl = '0; s0_in_data = '0; s0_in_tag = '0;
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_s0_in_ready", 128'(s0_in_ready), 128'(1));

        // 1: single beat, one-cycle latency, pops straight out
        ba = mk(11'h401, 16'hA5A5);
        drive(ba);
        out_ready = 1'b1;
        exp_q.push_back(ba);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 128'(out_valid), 128'(1));
        chk("t1_out_ctrl", 128'(out_ctrl), 128'(11'h401));
        chk("t1_out_instr", 128'(out_data[15:0]), 128'(16'hA5A5));
        chk("t1_occ_one", 128'(occupancy), 128'(1));
        tick();
        chk("t1_occ_zero", 128'(occupancy), 128'(0));
        chk("t1_bubble_ctrl", 128'(out_ctrl), 128'(0));

        // 2: stall fill, third beat held upstream, drain in order
        out_ready = 1'b0;
        ba = mk(11'h002, 16'h0001);
        drive(ba);
        exp_q.push_back(ba);
        tick();
        chk("t2_in_ready_one", 128'(in_ready), 128'(1));
        chk("t2_occ_one", 128'(occupancy), 128'(1));
        ba = mk(11'h004, 16'h0002);
        drive(ba);
        exp_q.push_back(ba);
        tick();
        chk("t2_in_ready_full", 128'(in_ready), 128'(0));
        chk("t2_occ_full", 128'(occupancy), 128'(2));
        bb = mk(11'h006, 16'h0003);
        drive(bb);
        tick();
        chk("t2_occ_held", 128'(occupancy), 128'(2));
        chk("t2_main_is_1", 128'(out_data[15:0]), 128'(16'h0001));
        out_ready = 1'b1;
        tick();
        chk("t2_occ_after_pop", 128'(occupancy), 128'(1));
        chk("t2_in_ready_back", 128'(in_ready), 128'(1));
        chk("t2_main_is_2", 128'(out_data[15:0]), 128'(16'h0002));
        exp_q.push_back(bb);
        tick();
        in_valid = 1'b0;
        chk("t2_occ_stream", 128'(occupancy), 128'(1));
        chk("t2_main_is_3", 128'(out_data[15:0]), 128'(16'h0003));
        tick();
        chk("t2_occ_drained", 128'(occupancy), 128'(0));

        // 3: flush while FULL drops held beats and the offered one
        out_ready = 1'b0;
        ba = mk(11'h00F, 16'h0011);
        drive(ba);
        tick();
        drive(mk(11'h00F, 16'h0022));
        tick();
        chk("t3_occ_full", 128'(occupancy), 128'(2));
        flush = 1'b1;
        drive(mk(11'h7FF, 16'h00FF));
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t3_out_valid", 128'(out_valid), 128'(0));
        chk("t3_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("t3_occ", 128'(occupancy), 128'(0));
        chk("t3_in_ready", 128'(in_ready), 128'(1));
        chk("t3_data_retained", 128'(out_data), 128'(ba.d));
        out_ready = 1'b1;
        tick();
        tick();
        chk("t3_still_empty", 128'(out_valid), 128'(0));

        // 4: streaming one beat per cycle
        for (int i = 0; i < 8; i++) begin
            ba = mk(11'h0F0 ^ 11'(i), 16'(i));
            drive(ba);
            exp_q.push_back(ba);
            chk("t4_in_ready", 128'(in_ready), 128'(1));
            tick();
            chk("t4_occ", 128'(occupancy), 128'(1));
            chk("t4_track", 128'(out_data[15:0]), 128'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("t4_occ_end", 128'(occupancy), 128'(0));

        // 5: async reset pulse while FULL
        out_ready = 1'b0;
        drive(mk(11'h123, 16'h0C01));
        tick();
        drive(mk(11'h321, 16'h0C02));
        tick();
        in_valid = 1'b0;
        chk("t5_occ_full", 128'(occupancy), 128'(2));
        #1 rst = 1'b0;
        #1;
        chk("t5_async_valid", 128'(out_valid), 128'(0));
        chk("t5_async_occ", 128'(occupancy), 128'(0));
        #1 rst = 1'b1;
        #1;
        chk("t5_in_ready", 128'(in_ready), 128'(1));
        chk("t5_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("t5_out_data", 128'(out_data), 128'(0));
        tick();
        chk("t5_stays_empty", 128'(occupancy), 128'(0));

        // 6: single-entry build, combinational ready, accept and pop together
        ba = mk(11'h00B, 16'h6001);
        drive0(ba);
        chk("t6_ready_empty", 128'(s0_in_ready), 128'(1));
        exp0_q.push_back(ba);
        tick();
        bb = mk(11'h00D, 16'h6002);
        drive0(bb);
        chk("t6_valid", 128'(s0_out_valid), 128'(1));
        chk("t6_ready_stall", 128'(s0_in_ready), 128'(0));
        chk("t6_occ", 128'(s0_occupancy), 128'(1));
        tick();
        chk("t6_occ_held", 128'(s0_occupancy), 128'(1));
        chk("t6_data_held", 128'(s0_out_data), 128'(ba.d));
        s0_out_ready = 1'b1;
        #1;
        chk("t6_ready_comb", 128'(s0_in_ready), 128'(1));
        exp0_q.push_back(bb);
        tick();
        s0_in_valid = 1'b0;
        chk("t6_new_valid", 128'(s0_out_valid), 128'(1));
        chk("t6_new_data", 128'(s0_out_data), 128'(bb.d));
        chk("t6_occ_swap", 128'(s0_occupancy), 128'(1));
        tick();
        chk("t6_empty", 128'(s0_out_valid), 128'(0));
        chk("t6_occ_zero", 128'(s0_occupancy), 128'(0));
        s0_out_ready = 1'b0;

        tick();
        chk("queues_drained", 128'(exp_q.size() + exp0_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
